// File: rtl/sorting_network_pipe_if.sv
// Stream bundle for the sorting network: upstream beat (valid/ready/data/mode/user)
// and downstream sorted beat. The master is the upstream/downstream side; the slave is the sorter.
interface sorting_network_pipe_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned USER_WIDTH = 2
);
  logic                             s_valid;
  logic                             s_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] s_data;
  logic [1:0]                       s_mode;
  logic [USER_WIDTH-1:0]            s_user;
  logic                             m_valid;
  logic                             m_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] m_sorted;
  logic [DATA_WIDTH-1:0]            m_data;
  logic [USER_WIDTH-1:0]            m_user;

  modport master (
    output s_valid, s_data, s_mode, s_user, m_ready,
    input  s_ready, m_valid, m_sorted, m_data, m_user
  );

  modport slave (
    input  s_valid, s_data, s_mode, s_user, m_ready,
    output s_ready, m_valid, m_sorted, m_data, m_user
  );
endinterface

// File: rtl/sorting_network_pipe.sv
// Fully pipelined odd-even transposition sorter: one compare-exchange rank per register stage,
// with mode/user carried alongside and a single global stall driven by the output stage.
module sorting_network_pipe #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_INPUTS = 5,
  parameter int unsigned USER_WIDTH = 2,
  parameter bit          SIGNED     = 1'b0
) (
  input logic                   i_clk,
  input logic                   i_areset,
  sorting_network_pipe_if.slave bus
);
  localparam int unsigned N   = NUM_INPUTS;
  localparam int unsigned W   = DATA_WIDTH;
  localparam int unsigned Mid = (N - 1) / 2;

  typedef logic [W-1:0] elem_t;

  elem_t                 stage_in [N][N];
  elem_t                 data_d   [N][N];
  elem_t                 data_q   [N][N];
  logic [N-1:0]          valid_q;
  logic [1:0]            mode_q   [N];
  logic [USER_WIDTH-1:0] user_q   [N];
  logic                  en;

  function automatic logic lt(elem_t a, elem_t b);
    if (SIGNED) return $signed(a) < $signed(b);
    return a < b;
  endfunction

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      stage_in[0][k] = bus.s_data[k*W +: W];
    end
    for (int unsigned p = 1; p < N; p++) begin
      for (int unsigned k = 0; k < N; k++) begin
        stage_in[p][k] = data_q[p-1][k];
      end
    end
    for (int unsigned p = 0; p < N; p++) begin
      for (int unsigned k = 0; k < N; k++) begin
        data_d[p][k] = stage_in[p][k];
      end
      // Stage index 0 is rank 1 (pairs 0-1, 2-3, ...); alternate ranks shift by one.
      for (int unsigned i = p % 2; i + 1 < N; i += 2) begin
        if (lt(stage_in[p][i+1], stage_in[p][i])) begin
          data_d[p][i]   = stage_in[p][i+1];
          data_d[p][i+1] = stage_in[p][i];
        end
      end
    end
  end

  assign en          = !valid_q[N-1] || bus.m_ready;
  assign bus.s_ready = en && !i_areset;

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      valid_q <= '0;
      for (int unsigned p = 0; p < N; p++) begin
        mode_q[p] <= '0;
        user_q[p] <= '0;
        for (int unsigned k = 0; k < N; k++) begin
          data_q[p][k] <= '0;
        end
      end
    end else if (en) begin
      valid_q   <= {valid_q[N-2:0], bus.s_valid};
      mode_q[0] <= bus.s_mode;
      user_q[0] <= bus.s_user;
      for (int unsigned p = 1; p < N; p++) begin
        mode_q[p] <= mode_q[p-1];
        user_q[p] <= user_q[p-1];
      end
      for (int unsigned p = 0; p < N; p++) begin
        for (int unsigned k = 0; k < N; k++) begin
          data_q[p][k] <= data_d[p][k];
        end
      end
    end
  end

  assign bus.m_valid = valid_q[N-1];
  assign bus.m_user  = user_q[N-1];

  always_comb begin
    for (int unsigned k = 0; k < N; k++) begin
      bus.m_sorted[k*W +: W] = data_q[N-1][k];
    end
    case (mode_q[N-1])
      2'd0:    bus.m_data = data_q[N-1][0];
      2'd2:    bus.m_data = data_q[N-1][N-1];
      default: bus.m_data = data_q[N-1][Mid];
    endcase
  end
endmodule

// File: tb/tb_sorting_network_pipe.sv
// Bench: unsigned and signed sorters fed the same stream, checked every cycle against a
// queue-based reference plus hand-computed literal expectations.
module tb_sorting_network_pipe;
  localparam int unsigned N = 5;
  localparam int unsigned W = 8;
  localparam int unsigned U = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           m_ready;
  logic [N*W-1:0] s_data;
  logic [1:0]     s_mode;
  logic [U-1:0]   s_user;

  sorting_network_pipe_if #(.DATA_WIDTH(W), .NUM_INPUTS(N), .USER_WIDTH(U)) bu ();
  sorting_network_pipe_if #(.DATA_WIDTH(W), .NUM_INPUTS(N), .USER_WIDTH(U)) bs ();

  assign bu.s_valid = s_valid;
  assign bu.s_data  = s_data;
  assign bu.s_mode  = s_mode;
  assign bu.s_user  = s_user;
  assign bu.m_ready = m_ready;
  assign bs.s_valid = s_valid;
  assign bs.s_data  = s_data;
  assign bs.s_mode  = s_mode;
  assign bs.s_user  = s_user;
  assign bs.m_ready = m_ready;

  sorting_network_pipe #(
    .DATA_WIDTH(W), .NUM_INPUTS(N), .USER_WIDTH(U), .SIGNED(1'b0)
  ) u_dut_u (
    .i_clk   (clk),
    .i_areset(rst),
    .bus     (bu)
  );

  sorting_network_pipe #(
    .DATA_WIDTH(W), .NUM_INPUTS(N), .USER_WIDTH(U), .SIGNED(1'b1)
  ) u_dut_s (
    .i_clk   (clk),
    .i_areset(rst),
    .bus     (bs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int             age;
    logic [N*W-1:0] su;
    logic [N*W-1:0] ss;
    logic [W-1:0]   du;
    logic [W-1:0]   ds;
    logic [U-1:0]   user;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic logic [N*W-1:0] sort_ref(input logic [N*W-1:0] d, input bit sgn);
    int             v[N];
    int             t;
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) begin
      if (sgn) v[k] = int'($signed(d[k*W +: W]));
      else     v[k] = int'({24'd0, d[k*W +: W]});
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N - 1 - i; j++) begin
        if (v[j] > v[j+1]) begin
          t = v[j]; v[j] = v[j+1]; v[j+1] = t;
        end
      end
    end
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = v[k][W-1:0];
    return r;
  endfunction

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] s, input logic [1:0] m);
    case (m)
      2'd0:    return s[W-1:0];
      2'd2:    return s[N*W-1 -: W];
      default: return s[((N-1)/2)*W +: W];
    endcase
  endfunction

  function automatic logic [N*W-1:0] pack5(input logic [7:0] a0, input logic [7:0] a1,
                                           input logic [7:0] a2, input logic [7:0] a3,
                                           input logic [7:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each accepted beat ages by one per advancing edge and is visible once age == N.
  always @(posedge rst) q.delete();

  always @(posedge clk) begin
    bit   mv;
    bit   adv;
    exp_t e;
    if (!rst) begin
      mv  = (q.size() > 0) && (q[0].age == N);
      adv = !mv || m_ready;
      if (mv && m_ready) void'(q.pop_front());
      if (adv) foreach (q[i]) q[i].age++;
      if (adv && s_valid) begin
        e.age  = 1;
        e.su   = sort_ref(s_data, 1'b0);
        e.ss   = sort_ref(s_data, 1'b1);
        e.du   = pick(e.su, s_mode);
        e.ds   = pick(e.ss, s_mode);
        e.user = s_user;
        q.push_back(e);
      end
    end
  end

  always begin
    bit mv;
    @(negedge clk);
    #2;
    mv = (q.size() > 0) && (q[0].age == N);
    chk("m_valid_u", bu.m_valid, mv);
    chk("m_valid_s", bs.m_valid, mv);
    chk("s_ready_u", bu.s_ready, !rst && (!mv || m_ready));
    chk("s_ready_s", bs.s_ready, !rst && (!mv || m_ready));
    if (rst) begin
      chk("rst_sorted_u", bu.m_sorted, 0);
      chk("rst_data_u", bu.m_data, 0);
      chk("rst_user_u", bu.m_user, 0);
      chk("rst_sorted_s", bs.m_sorted, 0);
    end else if (mv) begin
      chk("sorted_u", bu.m_sorted, q[0].su);
      chk("data_u", bu.m_data, q[0].du);
      chk("user_u", bu.m_user, q[0].user);
      chk("sorted_s", bs.m_sorted, q[0].ss);
      chk("data_s", bs.m_data, q[0].ds);
      chk("user_s", bs.m_user, q[0].user);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic beat(input logic [N*W-1:0] d, input logic [1:0] m, input logic [U-1:0] u);
    s_valid = 1'b1;
    s_data  = d;
    s_mode  = m;
    s_user  = u;
  endtask

  // Called right at a negedge; n counts negedges up to and including the first with m_valid.
  task automatic wait_valid(output int n);
    n = 1;
    #1;
    while (!bu.m_valid && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bu.m_valid) chk("timeout_m_valid", bu.m_valid, 1);
  endtask

  logic [N*W-1:0] hold_sorted;
  logic [W-1:0]   hold_data;
  int             n;

  initial begin
    rst     = 1'b1;
    s_valid = 1'b1;
    m_ready = 1'b1;
    s_data  = pack5(8'd1, 8'd2, 8'd3, 8'd4, 8'd5);
    s_mode  = 2'd1;
    s_user  = 2'd3;
    repeat (3) nxt();
    #1;
    chk("rst_s_ready", bu.s_ready, 0);
    chk("rst_m_valid", bu.m_valid, 0);
    nxt();
    rst     = 1'b0;
    s_valid = 1'b0;
    repeat (4) begin
      nxt();
      #1;
      chk("no_spurious", bu.m_valid, 0);
    end

    // Single beat
    nxt();
    beat(pack5(8'd10, 8'd5, 8'd7, 8'd200, 8'd0), 2'd1, 2'd2);
    nxt();
    s_valid = 1'b0;
    wait_valid(n);
    chk("latency", n, 5);
    chk("single_sorted", bu.m_sorted, {8'd200, 8'd10, 8'd7, 8'd5, 8'd0});
    chk("single_median", bu.m_data, 8'd7);
    chk("single_median_signed", bs.m_data, 8'd5);
    nxt();
    #1;
    chk("single_one_cycle", bu.m_valid, 0);

    // Back-to-back
    nxt();
    beat(pack5(8'd180, 8'd180, 8'd180, 8'd180, 8'd180), 2'd0, 2'd1);
    nxt();
    beat(pack5(8'd180, 8'd20, 8'd182, 8'd3, 8'd255), 2'd1, 2'd2);
    nxt();
    beat(pack5(8'd100, 8'd255, 8'd150, 8'd1, 8'd2), 2'd2, 2'd3);
    nxt();
    s_valid = 1'b0;
    wait_valid(n);
    chk("b2b0_data", bu.m_data, 8'd180);
    chk("b2b0_user", bu.m_user, 2'd1);
    nxt();
    #1;
    chk("b2b1_valid", bu.m_valid, 1);
    chk("b2b1_data", bu.m_data, 8'd180);
    chk("b2b1_data_signed", bs.m_data, 8'd255);
    chk("b2b1_user", bu.m_user, 2'd2);
    nxt();
    #1;
    chk("b2b2_valid", bu.m_valid, 1);
    chk("b2b2_data", bu.m_data, 8'd255);
    chk("b2b2_data_signed", bs.m_data, 8'd100);
    chk("b2b2_user", bu.m_user, 2'd3);
    nxt();
    #1;
    chk("b2b_end", bu.m_valid, 0);

    // Backpressure with signed/unsigned pattern
    nxt();
    beat(pack5(8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F), 2'd0, 2'd0);
    nxt();
    beat(pack5(8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F), 2'd1, 2'd1);
    nxt();
    beat(pack5(8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F), 2'd2, 2'd2);
    nxt();
    beat(pack5(8'hFF, 8'h00, 8'h01, 8'h80, 8'h7F), 2'd1, 2'd3);
    nxt();
    s_valid = 1'b0;
    m_ready = 1'b0;
    wait_valid(n);
    chk("bp_first_min_signed", bs.m_data, 8'h80);
    chk("bp_first_sorted", bu.m_sorted, {8'hFF, 8'h80, 8'h7F, 8'h01, 8'h00});
    hold_sorted = bu.m_sorted;
    hold_data   = bu.m_data;
    repeat (3) begin
      nxt();
      #1;
      chk("bp_hold_valid", bu.m_valid, 1);
      chk("bp_hold_sorted", bu.m_sorted, hold_sorted);
      chk("bp_hold_data", bu.m_data, hold_data);
      chk("bp_hold_s_ready", bu.s_ready, 0);
    end
    nxt();
    m_ready = 1'b1;
    #1;
    chk("bp_release_user", bu.m_user, 2'd0);
    nxt();
    #1;
    chk("bp_b2_median_signed", bs.m_data, 8'h00);
    chk("bp_b2_user", bu.m_user, 2'd1);
    nxt();
    #1;
    chk("bp_b3_max_signed", bs.m_data, 8'h7F);
    chk("bp_b3_user", bu.m_user, 2'd2);
    nxt();
    #1;
    chk("bp_b4_median_unsigned", bu.m_data, 8'h7F);
    chk("bp_b4_user", bu.m_user, 2'd3);
    nxt();
    #1;
    chk("bp_end", bu.m_valid, 0);

    // Asynchronous reset with beats in flight
    nxt();
    m_ready = 1'b0;
    beat(pack5(8'd9, 8'd8, 8'd7, 8'd6, 8'd5), 2'd0, 2'd1);
    nxt();
    beat(pack5(8'd1, 8'd9, 8'd2, 8'd8, 8'd3), 2'd1, 2'd2);
    nxt();
    beat(pack5(8'd4, 8'd4, 8'd4, 8'd4, 8'd4), 2'd2, 2'd3);
    nxt();
    s_valid = 1'b0;
    wait_valid(n);
    nxt();
    #3;
    rst     = 1'b1;
    s_valid = 1'b1;
    #1;
    chk("async_m_valid_u", bu.m_valid, 0);
    chk("async_m_valid_s", bs.m_valid, 0);
    chk("async_sorted", bu.m_sorted, 0);
    chk("async_s_ready", bu.s_ready, 0);
    repeat (3) nxt();
    nxt();
    rst     = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (8) begin
      nxt();
      #1;
      chk("post_rst_idle", bu.m_valid, 0);
    end

    // Recovery beat
    nxt();
    beat(pack5(8'd3, 8'd1, 8'd2, 8'd5, 8'd4), 2'd2, 2'd1);
    nxt();
    s_valid = 1'b0;
    wait_valid(n);
    chk("recover_latency", n, 5);
    chk("recover_max", bu.m_data, 8'd5);
    repeat (3) nxt();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sorting_network_pipe.md
Name: sorting_network_pipe

Overview:
- Parametrised, fully pipelined odd-even transposition sorting network over NUM_INPUTS samples of DATA_WIDTH bits.
- Generalises the fixed 3-input sorter to any odd input count, with signed/unsigned compare and a per-beat min/median/max output select.
- Adds a valid/ready stream handshake with backpressure.
- Sits in the median-filter datapath between the window buffer (NxN taps) and the output stream stage.

Parameters:
- DATA_WIDTH, 8, bits per sample.
- NUM_INPUTS, 5, number of samples sorted per beat; odd, 3..25.
- USER_WIDTH, 2, sideband bits carried alongside each beat (e.g. tlast/tuser).
- SIGNED, 0, 0 = unsigned compare, 1 = two's-complement compare.

Ports:
- i_clk  in  1  clock, all logic rising-edge.
- i_areset  in  1  reset, asynchronous, active-high.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  NUM_INPUTS*DATA_WIDTH  packed samples; sample k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_mode  in  2  per-beat select: 0 = min, 1 = median, 2 = max, 3 = median.
- s_user  in  USER_WIDTH  sideband, passed through unchanged.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_sorted  out  NUM_INPUTS*DATA_WIDTH  sorted ascending; element 0 (lowest bits) = minimum.
- m_data  out  DATA_WIDTH  value selected by that beat's s_mode.
- m_user  out  USER_WIDTH  sideband of the same beat.

Behaviour:
- Reset (i_areset = 1, asynchronous): all pipeline valid bits 0, all data/mode/user registers 0, so m_valid = 0 and m_sorted, m_data, m_user = 0.
- s_ready = 0 while i_areset is high. Any in-flight beats are discarded and never emitted.
- Pipeline: NUM_INPUTS registered stages. Stage p (p = 1..NUM_INPUTS) applies compare-exchange to its input vector:
  - odd p: pairs (0,1), (2,3), ...
  - even p: pairs (1,2), (3,4), ...
  - The last element passes straight through where it is unpaired.
  - Stage 1 operates on s_data directly. The output is the stage NUM_INPUTS register.
- Compare-exchange: lower index receives min(a,b), higher index receives max(a,b). Equal values are not swapped. Signedness follows SIGNED.
- The mode and user fields of each beat travel in lock-step with its data through every stage.
- m_data = m_sorted element 0 for mode 0, element (NUM_INPUTS-1)/2 for modes 1 and 3, element NUM_INPUTS-1 for mode 2. m_data is combinational from the output register.
- Global advance: en = !m_valid || m_ready.
  - s_ready = en; this is a combinational path from m_ready.
  - When en = 1, every stage loads from its predecessor, and stage 1 loads valid = s_valid.
  - When en = 0, all stages hold, including valid bits.
- Latency: a beat accepted at edge e appears with m_valid = 1 after edge e+NUM_INPUTS-1, i.e. NUM_INPUTS cycles, when there is no stall. Each stall cycle adds one.
- Throughput: 1 beat/cycle with m_ready held high.
- Bubbles (s_valid = 0 while en = 1) propagate as invalid slots; they are not collapsed.
- Under backpressure (m_valid && !m_ready), m_sorted, m_data and m_user hold stable until accepted.
- Simultaneous s_valid/s_ready and m_valid/m_ready in one cycle: the accept and the emit both occur, with no loss or duplication.
- Ordering: beats exit in acceptance order.

Test Plan:
- Reset: hold i_areset high 3 cycles with s_valid = 1 → m_valid = 0, s_ready = 0, all outputs 0. After release, no spurious beat.
- Single beat, N=5, W=8, s_data = {10,5,7,200,0}, mode 1, m_ready = 1 → m_valid high exactly 1 cycle, 5 cycles after accept. m_sorted = {0,5,7,10,200} (element 0 first), m_data = 7.
- Back-to-back beats with m_ready = 1:
  - {180,180,180,180,180} mode 0 → 180.
  - {180,20,182,3,255} mode 1 → 180.
  - {100,255,150,1,2} mode 2 → 255.
  - Required: 3 consecutive m_valid cycles, correct order, m_user matching.
- Backpressure: m_ready low 4 cycles while the first beat is at the output and 3 more are in flight → outputs stable, s_ready = 0 during the stall, all 4 beats later emitted in order, none lost.
- SIGNED=1: {0xFF,0x00,0x01,0x80,0x7F} → mode 0 gives 0x80, mode 1 gives 0x00, mode 2 gives 0x7F. With SIGNED=0, the same data in mode 1 gives 0x7F.
- Reset mid-stream: assert i_areset asynchronously (between edges) with 3 beats in flight → m_valid drops immediately. After release, nothing is emitted until new input arrives.
